// File: rtl/tff_toggle_debouncer_if.sv
// Button-to-TFF bundle: raw button level in, clean toggle request and status out.
interface tff_toggle_debouncer_if;
    logic btn_in;
    logic t_pulse;
    logic btn_stable;
    logic settling;

    modport master (
        output btn_in,
        input  t_pulse,
        input  btn_stable,
        input  settling
    );

    modport slave (
        input  btn_in,
        output t_pulse,
        output btn_stable,
        output settling
    );
endinterface

// File: rtl/tff_toggle_debouncer.sv
// Turns a bouncy asynchronous push-button level into one registered t_pulse per
// qualified press, via a 2-flop synchroniser, a run-length counter and a 4-state FSM.
module tff_toggle_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tff_toggle_debouncer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = '0;
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic             r_sync_p0;
    logic             r_sync_p1;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_t_pulse;
    logic             r_btn_stable;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_t_pulse_nxt;
    logic             w_btn_stable_nxt;

    // Stage p0 -> p1: metastability guard; only r_sync_p1 feeds the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= bus.btn_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Qualification stage: state, run counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE_LOW;
            r_cnt        <= ZERO_CNT;
            r_t_pulse    <= 1'b0;
            r_btn_stable <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_t_pulse    <= w_t_pulse_nxt;
            r_btn_stable <= w_btn_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_t_pulse_nxt    = 1'b0;
        w_btn_stable_nxt = r_btn_stable;

        unique case (r_state)
            IDLE_LOW: begin
                if (r_sync_p1) begin
                    // With a one-sample window the first high sample already qualifies.
                    if (SINGLE) begin
                        w_state_nxt      = STABLE_HIGH;
                        w_cnt_nxt        = ZERO_CNT;
                        w_btn_stable_nxt = 1'b1;
                        w_t_pulse_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = CHK_HIGH;
                        w_cnt_nxt   = ONE_CNT;
                    end
                end else begin
                    w_cnt_nxt = ZERO_CNT;
                end
            end

            CHK_HIGH: begin
                if (!r_sync_p1) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = ZERO_CNT;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt      = STABLE_HIGH;
                    w_cnt_nxt        = ZERO_CNT;
                    w_btn_stable_nxt = 1'b1;
                    w_t_pulse_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE_CNT;
                end
            end

            STABLE_HIGH: begin
                if (!r_sync_p1) begin
                    if (SINGLE) begin
                        w_state_nxt      = IDLE_LOW;
                        w_cnt_nxt        = ZERO_CNT;
                        w_btn_stable_nxt = 1'b0;
                    end else begin
                        w_state_nxt = CHK_LOW;
                        w_cnt_nxt   = ONE_CNT;
                    end
                end else begin
                    w_cnt_nxt = ZERO_CNT;
                end
            end

            CHK_LOW: begin
                if (r_sync_p1) begin
                    w_state_nxt = STABLE_HIGH;
                    w_cnt_nxt   = ZERO_CNT;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt      = IDLE_LOW;
                    w_cnt_nxt        = ZERO_CNT;
                    w_btn_stable_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + ONE_CNT;
                end
            end

            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = ZERO_CNT;
            end
        endcase
    end

    assign bus.t_pulse    = r_t_pulse;
    assign bus.btn_stable = r_btn_stable;
    assign bus.settling   = (r_state == CHK_HIGH) || (r_state == CHK_LOW);

endmodule

// File: tb/tb_tff_toggle_debouncer.sv
// Directed bench for the button debouncer driving a behavioural T flip-flop.
module tb_tff_toggle_debouncer;

    logic clk;
    logic rst;
    logic r_q = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulse_cnt = 0;
    int   pulse_mark;

    tff_toggle_debouncer_if bus ();

    tff_toggle_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // Downstream T flip-flop; never reset so its history spans the whole run.
    always @(posedge clk) if (bus.t_pulse) r_q <= ~r_q;

    always @(negedge clk) if (bus.t_pulse) pulse_cnt <= pulse_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Character i of each string gives btn_in before edge i and the outputs after it.
    task automatic run_seq(input string tag, input string b, input string ep,
                           input string es, input string est);
        for (int i = 0; i < b.len(); i++) begin
            bus.btn_in = (b[i] == "1");
            step();
            chk($sformatf("%s[%0d].t_pulse", tag, i), 32'(bus.t_pulse), 32'(ep[i] == "1"));
            chk($sformatf("%s[%0d].btn_stable", tag, i), 32'(bus.btn_stable), 32'(es[i] == "1"));
            chk($sformatf("%s[%0d].settling", tag, i), 32'(bus.settling), 32'(est[i] == "1"));
        end
    endtask

    initial begin
        rst        = 1'b0;
        bus.btn_in = 1'b0;

        // Reset held while the button chatters.
        for (int i = 0; i < 6; i++) begin
            bus.btn_in = i[0];
            step();
            chk($sformatf("rst_hold[%0d].t_pulse", i), 32'(bus.t_pulse), 32'd0);
            chk($sformatf("rst_hold[%0d].btn_stable", i), 32'(bus.btn_stable), 32'd0);
            chk($sformatf("rst_hold[%0d].settling", i), 32'(bus.settling), 32'd0);
        end
        bus.btn_in = 1'b0;
        rst = 1'b1;
        run_seq("idle", "0000", "0000", "0000", "0000");

        // Clean press and release.
        pulse_mark = pulse_cnt;
        run_seq("press", "1111111111", "0000010000", "0000011111", "0011100000");
        chk("press.q", 32'(r_q), 32'd1);
        run_seq("release", "00000000", "00000000", "11111000", "00111000");
        chk("press.pulses", 32'(pulse_cnt - pulse_mark), 32'd1);

        // Bounce during press: first burst aborted, one pulse 5 edges after final rise.
        pulse_mark = pulse_cnt;
        run_seq("bounce", "110111111111", "000000001000", "000000001111", "001101110000");
        run_seq("bounce_rel", "00000000", "00000000", "11111000", "00111000");
        chk("bounce.q", 32'(r_q), 32'd0);
        chk("bounce.pulses", 32'(pulse_cnt - pulse_mark), 32'd1);

        // Three-cycle glitch falls one sample short.
        pulse_mark = pulse_cnt;
        run_seq("glitch", "11100000", "00000000", "00000000", "00111000");
        chk("glitch.q", 32'(r_q), 32'd0);
        chk("glitch.pulses", 32'(pulse_cnt - pulse_mark), 32'd0);

        // Repeated presses; the last release bounces for two cycles.
        pulse_mark = pulse_cnt;
        run_seq("rep1", "11111111", "00000100", "00000111", "00111000");
        chk("rep1.q", 32'(r_q), 32'd1);
        run_seq("rep1_rel", "00000000", "00000000", "11111000", "00111000");
        run_seq("rep2", "11111111", "00000100", "00000111", "00111000");
        chk("rep2.q", 32'(r_q), 32'd0);
        run_seq("rep2_rel", "00000000", "00000000", "11111000", "00111000");
        run_seq("rep3", "11111111", "00000100", "00000111", "00111000");
        chk("rep3.q", 32'(r_q), 32'd1);
        run_seq("rep3_rel", "001100000000", "000000000000", "111111111000", "001100111000");
        chk("rep.pulses", 32'(pulse_cnt - pulse_mark), 32'd3);

        // Reset while t_pulse is high drops it without a clock.
        pulse_mark = pulse_cnt;
        run_seq("pre_rst", "111111", "000001", "000001", "001110");
        rst = 1'b0;
        #1;
        chk("rst_async.t_pulse", 32'(bus.t_pulse), 32'd0);
        chk("rst_async.btn_stable", 32'(bus.btn_stable), 32'd0);
        chk("rst_async.settling", 32'(bus.settling), 32'd0);
        run_seq("rst_low", "00", "00", "00", "00");
        rst = 1'b1;
        run_seq("post_rst", "0000", "0000", "0000", "0000");
        chk("rst_async.q", 32'(r_q), 32'd1);
        chk("rst_async.pulses", 32'(pulse_cnt - pulse_mark), 32'd0);

        // Reset mid-qualification with the button held through release.
        pulse_mark = pulse_cnt;
        run_seq("qual", "111", "000", "000", "001");
        rst = 1'b0;
        #1;
        chk("qual_rst.settling", 32'(bus.settling), 32'd0);
        run_seq("qual_rst", "11", "00", "00", "00");
        rst = 1'b1;
        run_seq("held", "1111111111", "0000010000", "0000011111", "0011100000");
        run_seq("held_rel", "00000000", "00000000", "11111000", "00111000");
        chk("held.q", 32'(r_q), 32'd0);
        chk("held.pulses", 32'(pulse_cnt - pulse_mark), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
